// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: opening flags, LSB-first payload with zero
// insertion, closing flag, abort pattern on host request or underrun.
module hdlc_tx_framer #(
  parameter int OPEN_FLAGS = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Start,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_DataValid,
  input  logic       Tx_Last,
  input  logic       Tx_AbortFrame,
  output logic       Tx_Ready,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FOPEN  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_FCLOSE = 3'd3;
  localparam logic [2:0] ST_ABORT  = 3'd4;

  localparam logic [7:0] FLAG      = 8'h7E;
  localparam logic [1:0] LAST_FLAG = 2'(OPEN_FLAGS - 1);

  // state_q always describes the bit currently held in tx_q
  logic [2:0] state_q, state_d;
  logic [2:0] bit_q,   bit_d;
  logic [1:0] flag_q,  flag_d;
  logic [2:0] ones_q,  ones_d;
  logic [7:0] shift_q, shift_d;
  logic       slast_q, slast_d;
  logic [7:0] hold_q,  hold_d;
  logic       hlast_q, hlast_d;
  logic       full_q,  full_d;
  logic       tx_q,    tx_d;
  logic       done_q,  done_d;
  logic       abtd_q,  abtd_d;

  logic       in_frame;
  logic       accept;
  logic       abort_req;
  logic       go_abort;
  logic       load;
  logic [2:0] ones_base;
  logic [2:0] bit_nx;

  assign in_frame  = (state_q == ST_FOPEN) |
                     (state_q == ST_DATA) |
                     (state_q == ST_FCLOSE);
  assign Tx_Ready  = (state_q == ST_IDLE) |
                     (~full_q & (state_q != ST_ABORT));
  assign accept    = Tx_DataValid & Tx_Ready;
  assign abort_req = Tx_AbortFrame & in_frame;
  assign bit_nx    = bit_q + 3'd1;

  assign Tx              = tx_q;
  assign Tx_ValidFrame   = in_frame;
  assign Tx_Done         = done_q;
  assign Tx_AbortedTrans = abtd_q;

  // next-bit selection, stuffing, holding register and abort handling
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    flag_d    = flag_q;
    ones_d    = ones_q;
    shift_d   = shift_q;
    slast_d   = slast_q;
    hold_d    = hold_q;
    hlast_d   = hlast_q;
    full_d    = full_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    abtd_d    = 1'b0;
    go_abort  = 1'b0;
    load      = 1'b0;
    ones_base = 3'd0;

    if (accept) begin
      hold_d  = Tx_Data;
      hlast_d = Tx_Last;
      full_d  = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (Tx_Start) begin
          state_d = ST_FOPEN;
          bit_d   = 3'd0;
          flag_d  = 2'd0;
          tx_d    = FLAG[0];
        end
      end
      ST_FOPEN: begin
        if (abort_req) begin
          go_abort = 1'b1;
        end else if (bit_q != 3'd7) begin
          bit_d = bit_nx;
          tx_d  = FLAG[bit_nx];
        end else if (flag_q != LAST_FLAG) begin
          flag_d = flag_q + 2'd1;
          bit_d  = 3'd0;
          tx_d   = FLAG[0];
        end else if (full_q) begin
          state_d = ST_DATA;
          load    = 1'b1;
        end else begin
          go_abort = 1'b1;
        end
      end
      ST_DATA: begin
        if (abort_req) begin
          go_abort = 1'b1;
        end else if (ones_q == 3'd5) begin
          tx_d   = 1'b0;
          ones_d = 3'd0;
        end else if (bit_q != 3'd7) begin
          bit_d  = bit_nx;
          tx_d   = shift_q[bit_nx];
          ones_d = shift_q[bit_nx] ? ones_q + 3'd1 : 3'd0;
        end else if (slast_q) begin
          state_d = ST_FCLOSE;
          bit_d   = 3'd0;
          tx_d    = FLAG[0];
        end else if (full_q) begin
          load      = 1'b1;
          ones_base = ones_q;
        end else begin
          go_abort = 1'b1;
        end
      end
      ST_FCLOSE: begin
        if (abort_req) begin
          go_abort = 1'b1;
        end else if (bit_q != 3'd7) begin
          bit_d = bit_nx;
          tx_d  = FLAG[bit_nx];
        end else begin
          state_d = ST_IDLE;
          bit_d   = 3'd0;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      ST_ABORT: begin
        tx_d = 1'b1;
        if (bit_q != 3'd7) begin
          bit_d = bit_nx;
        end else begin
          state_d = ST_IDLE;
          bit_d   = 3'd0;
          abtd_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      shift_d = hold_q;
      slast_d = hlast_q;
      full_d  = 1'b0;
      bit_d   = 3'd0;
      tx_d    = hold_q[0];
      ones_d  = hold_q[0] ? ones_base + 3'd1 : 3'd0;
    end

    if (go_abort) begin
      state_d = ST_ABORT;
      bit_d   = 3'd0;
      tx_d    = 1'b0;
      ones_d  = 3'd0;
      full_d  = 1'b0;
    end
  end

  // state registers, async active-low reset
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      bit_q   <= 3'd0;
      flag_q  <= 2'd0;
      ones_q  <= 3'd0;
      shift_q <= 8'd0;
      slast_q <= 1'b0;
      hold_q  <= 8'd0;
      hlast_q <= 1'b0;
      full_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      abtd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      flag_q  <= flag_d;
      ones_q  <= ones_d;
      shift_q <= shift_d;
      slast_q <= slast_d;
      hold_q  <= hold_d;
      hlast_q <= hlast_d;
      full_q  <= full_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      abtd_q  <= abtd_d;
    end
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: frames, stuffing,
// abort, underrun and asynchronous reset.
module tb_hdlc_tx_framer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Tx_Start;
  logic [7:0] Tx_Data;
  logic       Tx_DataValid;
  logic       Tx_Last;
  logic       Tx_AbortFrame;
  logic       Tx_Ready;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_AbortedTrans;
  logic       Tx_Done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic log_tx [4096];
  logic log_v  [4096];
  logic log_d  [4096];
  logic log_a  [4096];
  logic log_r  [4096];

  localparam string F = "01111110";

  hdlc_tx_framer #(.OPEN_FLAGS(1)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Tx_Start(Tx_Start),
    .Tx_Data(Tx_Data),
    .Tx_DataValid(Tx_DataValid),
    .Tx_Last(Tx_Last),
    .Tx_AbortFrame(Tx_AbortFrame),
    .Tx_Ready(Tx_Ready),
    .Tx(Tx),
    .Tx_ValidFrame(Tx_ValidFrame),
    .Tx_AbortedTrans(Tx_AbortedTrans),
    .Tx_Done(Tx_Done)
  );

  always #5 Clk = ~Clk;

  // one log entry per cycle, sampled mid-cycle
  always @(negedge Clk) begin
    if (cyc < 4096) begin
      log_tx[cyc] = Tx;
      log_v[cyc]  = Tx_ValidFrame;
      log_d[cyc]  = Tx_Done;
      log_a[cyc]  = Tx_AbortedTrans;
      log_r[cyc]  = Tx_Ready;
    end
    cyc = cyc + 1;
  end

  function automatic string obs(int s, int n);
    string r;
    r = "";
    for (int i = 0; i < n; i++)
      r = {r, (log_tx[s+i] === 1'b1) ? "1" : "0"};
    return r;
  endfunction

  function automatic int count(int which, int s, int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (which == 0 && log_v[s+i] === 1'b1) c++;
      if (which == 1 && log_d[s+i] === 1'b1) c++;
      if (which == 2 && log_a[s+i] === 1'b1) c++;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic last,
                      input logic start);
    bit ok;
    ok = 1'b0;
    Tx_Data      = d;
    Tx_Last      = last;
    Tx_DataValid = 1'b1;
    Tx_Start     = start;
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      if (Tx_Ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    Tx_DataValid = 1'b0;
    Tx_Start     = 1'b0;
    Tx_Last      = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL push_timeout got=no_ready exp=ready byte=%h", d);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({Tx, Tx_Ready, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done}
        !== 5'b11000) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=11000",
        {Tx, Tx_Ready, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done});
    end
  endtask

  task automatic test_idle();
    int s;
    string o;
    s = cyc;
    repeat (20) tick();
    o = obs(s, 20);
    total++;
    if (o != "11111111111111111111") begin
      bad++;
      $display("FAIL idle_tx got=%s exp=all_ones", o);
    end
    total++;
    if (count(0, s, 20) != 0) begin
      bad++;
      $display("FAIL idle_valid got=%0d exp=0", count(0, s, 20));
    end
  endtask

  task automatic test_single(input logic with_abort);
    int s;
    int f;
    string o;
    string e;
    s = cyc;
    Tx_AbortFrame = with_abort;
    push(8'h5A, 1'b1, 1'b1);
    Tx_AbortFrame = 1'b0;
    repeat (40) tick();
    f = -1;
    for (int i = s; i < s + 10; i++)
      if (f < 0 && log_v[i] === 1'b1) f = i;
    total++;
    if (f != s + 1) begin
      bad++;
      $display("FAIL single_latency got=%0d exp=%0d", f - s, 1);
    end
    o = obs(s + 1, 24);
    e = {F, "01011010", F};
    total++;
    if (o != e) begin
      bad++;
      $display("FAIL single_bits got=%s exp=%s", o, e);
    end
    total++;
    if (count(0, s, 40) != 24) begin
      bad++;
      $display("FAIL single_valid got=%0d exp=24", count(0, s, 40));
    end
    total++;
    if (count(1, s, 40) != 1 || log_d[s+25] !== 1'b1) begin
      bad++;
      $display("FAIL single_done got=%0d/%b exp=1/1",
        count(1, s, 40), log_d[s+25]);
    end
    total++;
    if (count(2, s, 40) != 0) begin
      bad++;
      $display("FAIL single_noabort got=%0d exp=0", count(2, s, 40));
    end
  endtask

  task automatic test_stuff();
    int s;
    string o;
    string e;
    s = cyc;
    push(8'hFF, 1'b0, 1'b1);
    push(8'h01, 1'b1, 1'b0);
    repeat (40) tick();
    o = obs(s + 1, 33);
    e = {F, "11111011110000000", F};
    total++;
    if (o != e) begin
      bad++;
      $display("FAIL stuff_bits got=%s exp=%s", o, e);
    end
    total++;
    if (count(0, s, 45) != 33 || log_d[s+34] !== 1'b1) begin
      bad++;
      $display("FAIL stuff_valid_done got=%0d/%b exp=33/1",
        count(0, s, 45), log_d[s+34]);
    end
  endtask

  task automatic test_stuff_last();
    int s;
    string o;
    string e;
    s = cyc;
    push(8'h1F, 1'b1, 1'b1);
    repeat (35) tick();
    o = obs(s + 1, 25);
    e = {F, "111110000", F};
    total++;
    if (o != e || log_d[s+26] !== 1'b1) begin
      bad++;
      $display("FAIL stuff_1f got=%s/%b exp=%s/1", o, log_d[s+26], e);
    end
    s = cyc;
    push(8'hF8, 1'b1, 1'b1);
    repeat (35) tick();
    o = obs(s + 1, 25);
    e = {F, "000111110", F};
    total++;
    if (o != e || log_d[s+26] !== 1'b1) begin
      bad++;
      $display("FAIL stuff_tail got=%s/%b exp=%s/1", o, log_d[s+26], e);
    end
  endtask

  task automatic test_abort();
    int s;
    string o;
    string e;
    s = cyc;
    push(8'h00, 1'b0, 1'b1);
    while (cyc < s + 11) tick();
    Tx_AbortFrame = 1'b1;
    Tx_Data       = 8'hFF;
    Tx_Last       = 1'b1;
    Tx_DataValid  = 1'b1;
    tick();
    Tx_AbortFrame = 1'b0;
    Tx_DataValid  = 1'b0;
    Tx_Last       = 1'b0;
    repeat (20) tick();
    o = obs(s + 1, 19);
    e = {F, "000", "01111111"};
    total++;
    if (o != e) begin
      bad++;
      $display("FAIL abort_bits got=%s exp=%s", o, e);
    end
    total++;
    if (count(2, s, 30) != 1 || log_a[s+20] !== 1'b1) begin
      bad++;
      $display("FAIL abort_pulse got=%0d/%b exp=1/1",
        count(2, s, 30), log_a[s+20]);
    end
    total++;
    if ({log_v[s+12], log_r[s+13], log_r[s+21]} !== 3'b001) begin
      bad++;
      $display("FAIL abort_valid_ready got=%b exp=001",
        {log_v[s+12], log_r[s+13], log_r[s+21]});
    end
    // a start with no data must underrun if the discarded byte is gone
    s = cyc;
    Tx_Start = 1'b1;
    tick();
    Tx_Start = 1'b0;
    repeat (25) tick();
    o = obs(s + 1, 16);
    e = {F, "01111111"};
    total++;
    if (o != e || log_a[s+17] !== 1'b1) begin
      bad++;
      $display("FAIL abort_flush got=%s/%b exp=%s/1", o, log_a[s+17], e);
    end
    test_single(1'b0);
  endtask

  task automatic test_underrun();
    int s;
    string o;
    string e;
    s = cyc;
    push(8'h00, 1'b0, 1'b1);
    repeat (30) tick();
    o = obs(s + 1, 24);
    e = {F, "00000000", "01111111"};
    total++;
    if (o != e) begin
      bad++;
      $display("FAIL underrun_bits got=%s exp=%s", o, e);
    end
    total++;
    if (log_a[s+25] !== 1'b1 || count(2, s, 30) != 1 ||
        count(1, s, 30) != 0) begin
      bad++;
      $display("FAIL underrun_pulse got=%b/%0d/%0d exp=1/1/0",
        log_a[s+25], count(2, s, 30), count(1, s, 30));
    end
  endtask

  task automatic test_reset_mid();
    int s;
    string o;
    s = cyc;
    push(8'h00, 1'b0, 1'b1);
    while (cyc < s + 10) tick();
    total++;
    if ({Tx, Tx_ValidFrame} !== 2'b01) begin
      bad++;
      $display("FAIL mid_pre got=%b exp=01", {Tx, Tx_ValidFrame});
    end
    #2;
    Rst = 1'b0;
    #1;
    total++;
    if ({Tx, Tx_Ready, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done}
        !== 5'b11000) begin
      bad++;
      $display("FAIL mid_reset got=%b exp=11000",
        {Tx, Tx_Ready, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done});
    end
    #3;
    Rst = 1'b1;
    tick();
    s = cyc;
    repeat (15) tick();
    o = obs(s, 15);
    total++;
    if (o != "111111111111111" || count(0, s, 15) != 0) begin
      bad++;
      $display("FAIL mid_after got=%s/%0d exp=all_ones/0",
        o, count(0, s, 15));
    end
  endtask

  initial begin
    Rst           = 1'b0;
    Tx_Start      = 1'b0;
    Tx_Data       = 8'h00;
    Tx_DataValid  = 1'b0;
    Tx_Last       = 1'b0;
    Tx_AbortFrame = 1'b0;
    #23;
    test_reset();
    Rst = 1'b1;
    tick();
    test_idle();
    test_single(1'b0);
    test_single(1'b1);
    test_stuff();
    test_stuff_last();
    test_abort();
    test_underrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
